// File: rtl/jtcps_vtiming_if.sv
// Video timing bundle for the CPS pipeline.
// Groups the pixel clock enable, the runtime vertical-sync adjustment
// handshake and every timing output produced by jtcps_vtiming.
//   master : the timing generator (drives counters, blanking, sync, busy)
//   slave  : the consumer / control side (drives cen, vadj, vadj_we)
interface jtcps_vtiming_if #(
  parameter int HW = 9,
  parameter int VW = 9
);
  logic                 cen;
  logic signed [3:0]    vadj;
  logic                 vadj_we;
  logic                 vadj_busy;
  logic [HW-1:0]        hdump;
  logic [VW-1:0]        vdump;
  logic [VW-1:0]        vrender;
  logic [VW-1:0]        vahead;
  logic                 line_start;
  logic                 frame_start;
  logic                 HB;
  logic                 VB;
  logic                 preVB;
  logic                 HS;
  logic                 VS;

  modport master (
    input  cen, vadj, vadj_we,
    output vadj_busy, hdump, vdump, vrender, vahead,
           line_start, frame_start, HB, VB, preVB, HS, VS
  );

  modport slave (
    output cen, vadj, vadj_we,
    input  vadj_busy, hdump, vdump, vrender, vahead,
           line_start, frame_start, HB, VB, preVB, HS, VS
  );
endinterface

// File: rtl/jtcps_vtiming.sv
// Parametrised video timing generator.
// Produces the pixel/line counters, line-ahead render counters, blanking and
// sync flags, plus a frame-synchronised vertical sync trim (vadj).
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   vif   : jtcps_vtiming_if.master
//           in : cen (pixel enable), vadj (signed line offset), vadj_we
//           out: vadj_busy, hdump, vdump, vrender, vahead, line_start,
//                frame_start, HB, VB, preVB, HS, VS (all registered)
module jtcps_vtiming #(
  parameter int HW       = 9,
  parameter int VW       = 9,
  parameter int HTOTAL   = 512,
  parameter int VTOTAL   = 262,
  parameter int HB_START = 448,
  parameter int HB_END   = 64,
  parameter int HS_START = 488,
  parameter int HS_END   = 18,
  parameter int VB_START = 238,
  parameter int VB_END   = 14,
  parameter int VS_START = 245,
  parameter int VS_LEN   = 4,
  parameter int AHEAD    = 2
) (
  input logic             clk,
  input logic             rst_n,
  jtcps_vtiming_if.master vif
);
  // Two guard bits so VS_START+vadj+VS_LEN never overflows before correction.
  localparam int SW = VW + 2;
  localparam logic [HW-1:0]        H_LAST  = HW'(HTOTAL - 1);
  localparam logic [VW-1:0]        V_LAST  = VW'(VTOTAL - 1);
  localparam logic signed [SW-1:0] V_TOT_S = SW'(VTOTAL);

  function automatic logic [VW-1:0] line_inc(input logic [VW-1:0] v);
    return (v == V_LAST) ? '0 : v + VW'(1);
  endfunction

  function automatic logic vblank(input logic [VW-1:0] v);
    return (v >= VW'(VB_START)) || (v < VW'(VB_END));
  endfunction

  // Single add/subtract correction back into 0..VTOTAL-1.
  function automatic logic signed [SW-1:0] line_wrap_s(input logic signed [SW-1:0] x);
    if (x < 0) return x + V_TOT_S;
    if (x >= V_TOT_S) return x - V_TOT_S;
    return x;
  endfunction

  logic [HW-1:0]     hdump_q, hdump_d;
  logic [VW-1:0]     vdump_q, vdump_d, vrender_q, vrender_d, vahead_q, vahead_d;
  logic              hb_q, hb_d, vb_q, vb_d, prevb_q, prevb_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic              ls_q, ls_d, fs_q, fs_d;
  logic signed [3:0] vadj_q, vadj_d, pend_q, pend_d;
  logic              busy_q, busy_d;

  logic                 line_wrap, frame_wrap, hs_set;
  logic [VW-1:0]        vrender_nx;
  logic signed [SW-1:0] vs_start_s, vs_end_s, vdump_s;

  always_comb begin
    line_wrap  = vif.cen && (hdump_q == H_LAST);
    frame_wrap = line_wrap && (vrender_q == '0);
    hs_set     = vif.cen && (hdump_q == HW'(HS_START));
    vrender_nx = line_inc(vrender_q);
    vs_start_s = line_wrap_s(SW'(VS_START) + SW'(vadj_q));
    vs_end_s   = line_wrap_s(vs_start_s + SW'(VS_LEN));
    vdump_s    = $signed({2'b00, vdump_q});

    hdump_d   = hdump_q;
    vdump_d   = vdump_q;
    vrender_d = vrender_q;
    vahead_d  = vahead_q;
    hb_d      = hb_q;
    vb_d      = vb_q;
    prevb_d   = prevb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    vadj_d    = vadj_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    // Pulses are recomputed every clk so they cannot stretch across cen gaps.
    ls_d      = line_wrap;
    fs_d      = frame_wrap;

    if (vif.cen) begin
      hdump_d = (hdump_q == H_LAST) ? '0 : hdump_q + HW'(1);
      hb_d    = (hdump_q >= HW'(HB_START)) || (hdump_q < HW'(HB_END));
      if (hdump_q == HW'(HS_START))    hs_d = 1'b1;
      else if (hdump_q == HW'(HS_END)) hs_d = 1'b0;
    end

    if (line_wrap) begin
      vdump_d   = vrender_q;
      vrender_d = vrender_nx;
      vahead_d  = line_inc(vahead_q);
      vb_d      = vblank(vrender_q);
      prevb_d   = vblank(vrender_nx);
    end

    // VS only moves together with the HS rising edge.
    if (hs_set) begin
      if (vdump_s == vs_start_s)    vs_d = 1'b1;
      else if (vdump_s == vs_end_s) vs_d = 1'b0;
    end

    // Apply first, then capture: a write on the applying cen stays pending.
    if (frame_wrap && busy_q) begin
      vadj_d = pend_q;
      busy_d = 1'b0;
    end
    if (vif.vadj_we) begin
      pend_d = vif.vadj;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdump_q   <= '0;
      vdump_q   <= '0;
      vrender_q <= VW'(1);
      vahead_q  <= VW'(AHEAD);
      hb_q      <= 1'b1;
      vb_q      <= 1'b1;
      prevb_q   <= 1'b1;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      vadj_q    <= '0;
      pend_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      hdump_q   <= hdump_d;
      vdump_q   <= vdump_d;
      vrender_q <= vrender_d;
      vahead_q  <= vahead_d;
      hb_q      <= hb_d;
      vb_q      <= vb_d;
      prevb_q   <= prevb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      vadj_q    <= vadj_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
    end
  end

  assign vif.hdump       = hdump_q;
  assign vif.vdump       = vdump_q;
  assign vif.vrender     = vrender_q;
  assign vif.vahead      = vahead_q;
  assign vif.HB          = hb_q;
  assign vif.VB          = vb_q;
  assign vif.preVB       = prevb_q;
  assign vif.HS          = hs_q;
  assign vif.VS          = vs_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.vadj_busy   = busy_q;

`ifndef SYNTHESIS
  initial begin
    if (HS_START == HS_END)  $error("jtcps_vtiming: HS_START must differ from HS_END");
    if (VS_LEN < 1)          $error("jtcps_vtiming: VS_LEN must be at least 1");
    if (VS_LEN + 8 >= VTOTAL) $error("jtcps_vtiming: VS_LEN+8 must be below VTOTAL");
    if (AHEAD >= VTOTAL)     $error("jtcps_vtiming: AHEAD must be below VTOTAL");
  end
`endif
endmodule
